// File: rtl/instr_fetch.sv
// Instruction fetch controller: pulls the instruction at pc_addr from memory,
// holds it for the decoder and pulses pc_enable once per captured instruction.
module instr_fetch #(
    parameter int IW = 16,
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [AW-1:0] pc_addr,
    output logic          pc_enable,
    output logic          mem_req,
    output logic [AW-1:0] mem_addr,
    input  logic [IW-1:0] mem_rdata,
    input  logic          mem_ready,
    output logic          ir_valid,
    input  logic          ir_ready,
    output logic [IW-1:0] ir_data,
    output logic [AW-1:0] ir_pc,
    input  logic          flush
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t          state_r;
    state_t          next_state_s;
    logic            capture_s;
    logic            mem_req_s;
    logic            pc_enable_s;
    logic            ir_valid_r;
    logic [IW-1:0]   ir_data_r;
    logic [AW-1:0]   ir_pc_r;

    // Next-state and handshake decode; flush outranks any memory completion.
    always_comb begin
        next_state_s = state_r;
        mem_req_s    = 1'b0;
        pc_enable_s  = 1'b0;
        capture_s    = 1'b0;
        case (state_r)
            IDLE: begin
                next_state_s = FETCH;
            end
            FETCH: begin
                if (flush) begin
                    pc_enable_s  = 1'b1;
                    next_state_s = FETCH;
                end else begin
                    mem_req_s = 1'b1;
                    if (mem_ready) begin
                        capture_s    = 1'b1;
                        pc_enable_s  = 1'b1;
                        next_state_s = HOLD;
                    end else begin
                        next_state_s = FETCH;
                    end
                end
            end
            HOLD: begin
                if (flush) begin
                    pc_enable_s  = 1'b1;
                    next_state_s = FETCH;
                end else if (ir_ready) begin
                    // Prefetch only while the held slot is being freed.
                    mem_req_s = 1'b1;
                    if (mem_ready) begin
                        capture_s    = 1'b1;
                        pc_enable_s  = 1'b1;
                        next_state_s = HOLD;
                    end else begin
                        next_state_s = FETCH;
                    end
                end else begin
                    next_state_s = HOLD;
                end
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Instruction register; valid exactly while the FSM sits in HOLD.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ir_valid_r <= 1'b0;
            ir_data_r  <= {IW{1'b0}};
            ir_pc_r    <= {AW{1'b0}};
        end else begin
            ir_valid_r <= (next_state_s == HOLD);
            if (capture_s) begin
                ir_data_r <= mem_rdata;
                ir_pc_r   <= pc_addr;
            end
        end
    end

    assign mem_req   = mem_req_s;
    assign pc_enable = pc_enable_s;
    assign mem_addr  = pc_addr;
    assign ir_valid  = ir_valid_r;
    assign ir_data   = ir_data_r;
    assign ir_pc     = ir_pc_r;

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch controller for the 8-bit RISC CPU: the consumer side of the program counter interface. It takes the current PC value and fetches the instruction at that address from instruction memory using a ready handshake. It presents the instruction to the decoder through a valid/ready handshake and pulses `pc_enable` so the PC advances exactly once per fetched instruction. A `flush` input discards fetched or in-flight work when a branch is taken.

## Interface
Parameters:
- `IW`, default 16: instruction width in bits.
- `AW`, default 8: address width; matches the PC width.

Ports:
- `clk` in 1: clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `pc_addr` in AW: current PC value (the PC register output).
- `pc_enable` out 1: one-cycle pulse that advances the PC. Combinational. The PC increments on the pulse, or loads its target when the execute unit also drives `pc_load`.
- `mem_req` out 1: fetch request to instruction memory. Combinational.
- `mem_addr` out AW: fetch address; equals `pc_addr` (combinational pass-through).
- `mem_rdata` in IW: instruction word; valid when `mem_req` && `mem_ready`.
- `mem_ready` in 1: memory completes the request this cycle. Ignored when `mem_req`=0.
- `ir_valid` out 1: instruction register holds an instruction for the decoder. Registered.
- `ir_ready` in 1: decoder accepts; a transfer occurs when `ir_valid` && `ir_ready`.
- `ir_data` out IW: held instruction. Registered.
- `ir_pc` out AW: address the held instruction was fetched from. Registered.
- `flush` in 1: branch taken; discard all fetch state. Single-cycle pulse from execute.

## Operation
- States: IDLE, FETCH, HOLD.
- IDLE:
  - Entered on reset. Drives `mem_req`=0 and `pc_enable`=0.
  - Goes unconditionally to FETCH on the next clock.
- FETCH:
  - `mem_req`=1.
  - On `mem_ready`:
    - load `ir_data`<=`mem_rdata` and `ir_pc`<=`pc_addr`;
    - set `ir_valid`<=1;
    - assert `pc_enable`=1 in the same cycle;
    - go to HOLD.
  - Without `mem_ready`: stay in FETCH. `pc_enable`=0, so `pc_addr`/`mem_addr` stay stable while waiting.
- HOLD:
  - `ir_valid`=1; `ir_data`/`ir_pc` stable until transfer.
  - `mem_req` = `ir_ready` (prefetch only when the held slot is being freed).
  - `ir_ready` && `mem_ready`: reload `ir_data`/`ir_pc` from memory, pulse `pc_enable`, stay in HOLD. This gives back-to-back throughput of 1 instruction per cycle.
  - `ir_ready` && !`mem_ready`: `ir_valid`<=0, go to FETCH.
  - !`ir_ready`: hold; `mem_req`=0, `pc_enable`=0.
- `flush` has the highest priority in FETCH and HOLD:
  - `mem_req` is forced to 0 that cycle, and any `mem_ready` is ignored.
  - `pc_enable`=1, so the PC loads the branch target via the external `pc_load`.
  - `ir_valid`<=0; next state FETCH.
- `flush` in IDLE: ignored; `pc_enable` stays 0.
- Memory may see a request withdrawn without completion (flush). Memory shall tolerate this.
- Address wrap is handled by the PC: a fetch at 0xFF gives `ir_pc`=0xFF, and the next fetch is at 0x00.
- `pc_enable` is never asserted more than once per captured instruction, except for the flush pulse.

## Timing
- Reset values:
  - state IDLE;
  - `ir_valid`=0, `ir_data`=0, `ir_pc`=0;
  - `mem_req`=0, `pc_enable`=0.
- Reset is asynchronous; asserting it mid-fetch abandons the request immediately.
- First request: the cycle after the first clock edge with `reset` low (IDLE→FETCH).
- Fetch latency: a memory response in cycle N gives `ir_valid`=1 in N+1, and the PC shows the new value in N+1.
- Zero-wait memory with `ir_ready` held high: one new `ir_data` per cycle, `pc_enable` high continuously.
- Flush in cycle N:
  - `ir_valid`=0 in N+1;
  - `mem_req`=1 for the target address in N+1;
  - earliest new instruction valid in N+2.
- Outputs `mem_req`, `mem_addr`, `pc_enable` are combinational from state and inputs. `ir_*` are registered.

## Test plan
- Reset, then zero-wait memory returning `mem_rdata`=0x1000+addr, with `ir_ready`=1:
  - `mem_req` goes high 1 cycle after reset release;
  - `ir_pc` = 0,1,2,3 on consecutive cycles, with `ir_data`=0x1000..0x1003;
  - `pc_enable` high every cycle.
- Memory with 3 wait states:
  - `mem_addr` stable for 4 cycles;
  - `pc_enable` pulses only in the `mem_ready` cycle;
  - `ir_valid` rises the cycle after.
- Decoder backpressure (`ir_ready`=0 for 5 cycles while `ir_valid`=1):
  - `ir_data`/`ir_pc` stable;
  - `mem_req`=0, `pc_enable`=0 throughout;
  - on release, transfer plus prefetch in the same cycle.
- Flush while in FETCH with `mem_ready`=1 in the same cycle:
  - the instruction is not captured;
  - `pc_enable`=1;
  - the next fetch uses the loaded target (e.g. 0x40), giving `ir_pc`=0x40.
- Flush while in HOLD with `ir_valid`=1:
  - `ir_valid`=0 next cycle, and no transfer of the stale instruction.
- PC at 0xFE, zero-wait memory:
  - `ir_pc` sequence 0xFE, 0xFF, 0x00.
- `reset` asserted mid-wait:
  - all outputs at reset values immediately;
  - the fetch restarts at address 0.
